// File: rtl/bit8_pkg.sv
// Shared types and constants for the bit8 serial-to-parallel expander.
// Holds the FSM state type and the default output width.
package bit8_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  localparam int DESER_WIDTH = 8;

endpackage

// File: rtl/shift_in8.sv
// Position register: writes one bit at slot cnt per enable, LSB first.
// Holds the partial word and the wrapping bit counter.
module shift_in8
  import bit8_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic                     din,
  output logic [WIDTH-1:0]         word,
  output logic [$clog2(WIDTH)-1:0] cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // store bit at slot cnt, advance cnt and wrap after the last slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (we) begin
      word[cnt] <= din;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit8_deser.sv
// 1-to-WIDTH serial deserializer with registered valid/ready output.
// Optional out_nz flag enabled by defining DESER_NZ_FLAG_EN.
module bit8_deser
  import bit8_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
`ifdef DESER_NZ_FLAG_EN
  output logic             out_nz,
`endif
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sh_word;
  logic [CW-1:0]    cnt;
  logic             we;
  logic             ld;
  logic [WIDTH-1:0] ld_word;

  shift_in8 #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .we    (we),
    .din   (in_bit),
    .word  (sh_word),
    .cnt   (cnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= nxt;
  end

  // next state, accept enable and output-load decode
  always_comb begin
    nxt      = state;
    in_ready = (state == COLLECT);
    we       = 1'b0;
    ld       = 1'b0;
    ld_word  = sh_word;
    unique case (1'b1)
      (state == COLLECT): begin
        we = in_valid;
        if (in_valid && cnt == LAST) begin
          if (!out_valid || out_ready) begin
            ld      = 1'b1;
            ld_word = {in_bit, sh_word[WIDTH-2:0]};
          end else begin
            nxt = STALL;
          end
        end
      end
      (state == STALL): begin
        if (out_ready) begin
          ld  = 1'b1;
          nxt = COLLECT;
        end
      end
      default: ;
    endcase
    if (clear) begin
      nxt = COLLECT;
      we  = 1'b0;
      ld  = 1'b0;
    end
  end

  // output register: load a finished word or drop valid on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (ld) begin
      out_word  <= ld_word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DESER_NZ_FLAG_EN
  // nonzero flag tracks whichever word was last loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     out_nz <= 1'b0;
    else if (clear) out_nz <= 1'b0;
    else if (ld)    out_nz <= |ld_word;
  end
`endif

endmodule

// File: tb/tb_bit8_deser.sv
// Scoreboard bench for bit8_deser: directed words, queued expectations,
// negedge monitor pops on every output transfer.
module tb_bit8_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_word;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef DESER_NZ_FLAG_EN
  logic       out_nz;
`endif

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  logic [7:0] exp_q[$];

  bit8_deser #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
`ifdef DESER_NZ_FLAG_EN
    .out_nz    (out_nz),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // monitor: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %0h want none", out_word);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_word !== e) begin
          errors++;
          $display("FAIL word: got %0h want %0h", out_word, e);
        end
`ifdef DESER_NZ_FLAG_EN
        checks++;
        if (out_nz !== (|e)) begin
          errors++;
          $display("FAIL nz: got %0b want %0b", out_nz, |e);
        end
`endif
      end
    end
  end

  // present one bit, require in_ready, count out_valid cycles
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    chk("in_ready_stream", in_ready, 1);
    if (out_valid) vcnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state while rst_n is low
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_ready", in_ready, 1);
`ifdef DESER_NZ_FLAG_EN
    chk("rst_nz", out_nz, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // single word 4D, one-cycle valid pulse
    exp_q.push_back(8'h4D);
    vcnt = 0;
    send_word(8'h4D);
    @(negedge clk);
    chk("t1_valid_after_last", out_valid, 1);
    chk("t1_word", out_word, 8'h4D);
    @(posedge clk);
    #1;
    vcnt = 0;
    idle(3);
    chk("t1_pulse_len", vcnt, 0);

    // back-to-back A5, 3C
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    vcnt = 0;
    send_word(8'hA5);
    send_word(8'h3C);
    idle(3);
    chk("t2_valid_cycles", vcnt, 2);

    // backpressure: FF then 01 with out_ready low
    out_ready = 1'b0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    send_word(8'hFF);
    send_word(8'h01);
    @(negedge clk);
    chk("t3_stall_ready", in_ready, 0);
    chk("t3_hold_word", out_word, 8'hFF);
    chk("t3_hold_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_second_word", out_word, 8'h01);
    chk("t3_second_valid", out_valid, 1);
    chk("t3_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(2);

    // clear discards held word 55 and a 5-bit partial
    out_ready = 1'b0;
    send_word(8'h55);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("t4_clr_valid", out_valid, 0);
    chk("t4_clr_word", out_word, 0);
    chk("t4_clr_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(8'h80);
    send_word(8'h80);
    idle(2);

    // async reset mid-word with a held output word
    out_ready = 1'b0;
    send_word(8'h96);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_word", out_word, 0);
    chk("t5_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'h0F);
    send_word(8'h0F);
    idle(2);

    // zero and nonzero words for the nz flag
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h10);
    send_word(8'h00);
    send_word(8'h10);
    idle(2);

    // drain bound
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit8_deser.md
# bit8_deser

Serial-to-parallel expander: accepts one bit per cycle on a valid/ready input and assembles 8-bit words LSB-first. Each completed word is presented on a registered valid/ready output. It sits between single-bit producers (gate-level serial links, test stimulus) and the 8-bit datapath. It also provides the 1→8 widening counterpart to the team's 8→1 reduction gates.

## Interface
- WIDTH, 8, output word width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; discards the partial word and the held output word.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  block accepts in_bit this cycle.
- out_word  out  WIDTH  assembled word; bit 0 is the first bit accepted.
- out_valid  out  1  out_word holds an unconsumed word.
- out_ready  in  1  consumer takes out_word this cycle.
- out_nz  out  1  OR of all out_word bits; present only with DESER_NZ_FLAG_EN.

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Accepted bit is written to shifter position cnt; cnt increments. cnt is a $clog2(WIDTH)-bit counter, range 0..WIDTH-1.
- State COLLECT:
  - in_ready = 1.
  - When the bit accepted at cnt = WIDTH-1 completes a word:
    - If the output register is empty, or is transferring this same cycle, the word loads into out_word and out_valid = 1. cnt wraps to 0 and the state stays COLLECT.
    - Otherwise the state goes to STALL and the word is held in the shifter.
- State STALL:
  - in_ready = 0.
  - On an output transfer, the shifter word loads into out_word, out_valid stays 1, cnt = 0, and the state goes to COLLECT.
- Without an output transfer, out_word and out_valid hold. out_word is stable while out_valid = 1.
- clear has priority over all handshakes. On clear: cnt = 0, state = COLLECT, out_valid = 0, out_word = 0. Any transfer in the same cycle is void.
- Reset values: out_word 0, out_valid 0, out_nz 0, cnt 0, state COLLECT, so in_ready = 1 while rst_n is low.

## Timing
- in_ready is a combinational decode of state only. It never depends on in_valid or out_ready.
- Latency: out_valid rises on the clock edge that accepts the final bit, i.e. it is visible the cycle after that bit is presented.
- Throughput: one bit per cycle sustained, i.e. one word every WIDTH cycles, provided each word transfers before the next word completes.
- Backpressure: with out_ready held low, the block accepts exactly 2·WIDTH bits and then deasserts in_ready.
- Simultaneous final-bit accept and output transfer: the new word replaces the old one with no bubble and no stall.
- Reset asserted mid-word: the partial word is lost and no output is produced.

## Configuration
- DESER_NZ_FLAG_EN defined:
  - out_nz is a register loaded with |word whenever out_word loads.
  - It is cleared by reset and clear.
  - It is valid exactly when out_valid = 1.
- DESER_NZ_FLAG_EN undefined: the out_nz port and its register are absent, and all other behaviour is identical.

## Structure
- Package bit8_pkg contains:
  - the state typedef (COLLECT, STALL);
  - the default width constant DESER_WIDTH = 8.
- Sub-module shift_in8: WIDTH-bit shift/position register with a write-enable and a synchronous clear. It holds the partial word and the counter.
- The top level holds the FSM, the output register and the optional nz flag.

## Test plan
- Reset, then feed bits 1,0,1,1,0,0,1,0 with in_valid = 1 and out_ready = 1: out_word = 8'h4D, and out_valid pulses for one cycle after the 8th bit.
- Continuous stream of 16 bits encoding 8'hA5 then 8'h3C, out_ready = 1: two words arrive back-to-back with out_valid high in exactly 2 cycles, and in_ready never drops.
- out_ready = 0 while streaming 8'hFF then 8'h01: in_ready drops after bit 16, and out_word holds 8'hFF. Raise out_ready for one cycle: out_word becomes 8'h01 and in_ready returns.
- Assert clear after 5 bits: cnt returns to 0. The next 8 bits 8'h80 yield out_word = 8'h80 with no partial data mixed in.
- Drop rst_n mid-word while out_valid = 1: out_valid = 0, out_word = 0 and in_ready = 1 immediately, without waiting for a clock edge.
- With DESER_NZ_FLAG_EN: word 8'h00 gives out_nz = 0, and word 8'h10 gives out_nz = 1, aligned with out_valid.
